// File: rtl/token_queue_pkg.sv
// Shared types for the RLL -> execute token path: the packed token layout,
// its width, and a saturating add used by the squash statistics counter.
package token_queue_pkg;

    typedef enum logic [7:0] {
        IT_ALU    = 8'h00,
        IT_LOAD   = 8'h01,
        IT_STORE  = 8'h02,
        IT_BRANCH = 8'h03,
        IT_JUMP   = 8'h04
    } instruction_type;

    typedef enum logic [3:0] {
        XU_INT = 4'h0,
        XU_MEM = 4'h1,
        XU_BR  = 4'h2
    } xu;

    typedef struct packed {
        logic [31:0]     opA;
        logic [31:0]     opB;
        logic [31:0]     opC;
        logic [31:0]     NPC;
        instruction_type i;
        xu               xu_sel;
    } token_t;

    localparam int TOKEN_W = $bits(token_t);
    localparam int SQ_W    = 16;

    function automatic logic [SQ_W-1:0] sat_add(input logic [SQ_W-1:0] a,
                                                 input logic [SQ_W-1:0] b);
        logic [SQ_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SQ_W] ? '1 : s[SQ_W-1:0];
    endfunction

endpackage

// File: rtl/token_queue_ring_ptr.sv
// Circular pointer increment that wraps DEPTH-1 -> 0 for any DEPTH,
// including non-power-of-two sizes.
module ring_ptr #(
    parameter int DEPTH = 2,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [PTR_W-1:0] i_ptr,
    input  logic             i_adv,
    output logic [PTR_W-1:0] o_next
);

    logic w_at_last;

    assign w_at_last = (i_ptr == PTR_W'(DEPTH - 1));

    always_comb begin
        o_next = i_ptr;
        if (i_adv) begin
            o_next = w_at_last ? '0 : i_ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/token_queue.sv
// Elastic circular token FIFO between register-lock and execute, with
// valid/ready on both sides and tag-based squash of in-flight tokens.
module token_queue
    import token_queue_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int DATA_W      = TOKEN_W,
    parameter int TAG_W       = 4,
    parameter int FALLTHROUGH = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [TAG_W-1:0]             out_tag,
    input  logic                         squash,
    input  logic [TAG_W-1:0]             squash_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic [15:0]                  squashed
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam bit FT    = (FALLTHROUGH != 0);

    // Handshake: a transfer happens on a side when valid && ready are both
    // high at the rising edge; in_ready depends on registered occupancy only.
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [TAG_W-1:0]  r_tag  [DEPTH];
    logic [DEPTH-1:0]  r_live;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [15:0]       r_squashed;

    logic [PTR_W-1:0]  w_head_next;
    logic [PTR_W-1:0]  w_tail_next;
    logic [15:0]       w_kill_cnt;
    logic              w_empty;
    logic              w_full;
    logic              w_fall;
    logic              w_in_kill;
    logic              w_head_kill;
    logic              w_push;
    logic              w_out_valid;
    logic              w_ft_pass;
    logic              w_ft_drop;
    logic              w_write;
    logic              w_pop;
    logic              w_skip;
    logic              w_adv;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_fall      = FT && w_empty;
    assign w_in_kill   = squash && (in_tag != squash_tag);
    assign w_head_kill = squash && (r_tag[r_head] != squash_tag);
    assign w_push      = in_valid && !w_full;

    assign w_out_valid = w_fall ? (in_valid && !w_in_kill)
                                : (!w_empty && r_live[r_head] && !w_head_kill);

    // An empty fallthrough queue never stores what it forwards or kills.
    assign w_ft_pass = w_fall && in_valid && out_ready && !w_in_kill;
    assign w_ft_drop = w_fall && in_valid && w_in_kill;
    assign w_write   = w_push && !w_ft_pass && !w_ft_drop;

    assign w_pop  = !w_empty && w_out_valid && out_ready;
    assign w_skip = !w_empty && !r_live[r_head];
    assign w_adv  = w_pop || w_skip;

    ring_ptr #(.DEPTH(DEPTH)) u_head_ptr (
        .i_ptr  (r_head),
        .i_adv  (w_adv),
        .o_next (w_head_next)
    );

    ring_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
        .i_ptr  (r_tail),
        .i_adv  (w_write),
        .o_next (w_tail_next)
    );

    // Live bits are cleared on dequeue, so live implies occupied here.
    always_comb begin
        w_kill_cnt = '0;
        if (squash) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_live[i] && (r_tag[i] != squash_tag)) begin
                    w_kill_cnt = w_kill_cnt + 16'd1;
                end
            end
            if (w_push && w_in_kill) begin
                w_kill_cnt = w_kill_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_live     <= '0;
            r_squashed <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else begin
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_count <= r_count + CNT_W'(w_write) - CNT_W'(w_adv);
            if (squash) begin
                r_squashed <= sat_add(r_squashed, w_kill_cnt);
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_tag[i] != squash_tag) begin
                        r_live[i] <= 1'b0;
                    end
                end
            end
            if (w_adv) begin
                r_live[r_head] <= 1'b0;
            end
            if (w_write) begin
                r_data[r_tail] <= in_data;
                r_tag[r_tail]  <= in_tag;
                r_live[r_tail] <= !w_in_kill;
            end
        end
    end

    assign in_ready  = !w_full;
    assign out_valid = w_out_valid;
    assign out_data  = (w_fall && in_valid) ? in_data : r_data[r_head];
    assign out_tag   = (w_fall && in_valid) ? in_tag  : r_tag[r_head];
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign squashed  = r_squashed;

endmodule

// File: tb/tb_token_queue.sv
// Directed bench for token_queue: three instances (DEPTH=2, DEPTH=3, and a
// DEPTH=2 fallthrough) share one stimulus bus; each scenario checks one of them.
module tb_token_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [3:0]  in_tag = '0;
    logic        out_ready = 1'b0;
    logic        squash = 1'b0;
    logic [3:0]  squash_tag = '0;

    logic        d2_in_ready, d2_out_valid, d2_full, d2_empty;
    logic [15:0] d2_out_data, d2_squashed;
    logic [3:0]  d2_out_tag;
    logic [1:0]  d2_count;

    logic        d3_in_ready, d3_out_valid, d3_full, d3_empty;
    logic [15:0] d3_out_data, d3_squashed;
    logic [3:0]  d3_out_tag;
    logic [1:0]  d3_count;

    logic        ft_in_ready, ft_out_valid, ft_full, ft_empty;
    logic [15:0] ft_out_data, ft_squashed;
    logic [3:0]  ft_out_tag;
    logic [1:0]  ft_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    token_queue #(.DEPTH(2), .DATA_W(16), .TAG_W(4), .FALLTHROUGH(0)) u_d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d2_in_ready),
        .in_data(in_data), .in_tag(in_tag), .out_valid(d2_out_valid),
        .out_ready(out_ready), .out_data(d2_out_data), .out_tag(d2_out_tag),
        .squash(squash), .squash_tag(squash_tag), .count(d2_count),
        .full(d2_full), .empty(d2_empty), .squashed(d2_squashed)
    );

    token_queue #(.DEPTH(3), .DATA_W(16), .TAG_W(4), .FALLTHROUGH(0)) u_d3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d3_in_ready),
        .in_data(in_data), .in_tag(in_tag), .out_valid(d3_out_valid),
        .out_ready(out_ready), .out_data(d3_out_data), .out_tag(d3_out_tag),
        .squash(squash), .squash_tag(squash_tag), .count(d3_count),
        .full(d3_full), .empty(d3_empty), .squashed(d3_squashed)
    );

    token_queue #(.DEPTH(2), .DATA_W(16), .TAG_W(4), .FALLTHROUGH(1)) u_ft (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ft_in_ready),
        .in_data(in_data), .in_tag(in_tag), .out_valid(ft_out_valid),
        .out_ready(out_ready), .out_data(ft_out_data), .out_tag(ft_out_tag),
        .squash(squash), .squash_tag(squash_tag), .count(ft_count),
        .full(ft_full), .empty(ft_empty), .squashed(ft_squashed)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_data    = '0;
        in_tag     = '0;
        out_ready  = 1'b0;
        squash     = 1'b0;
        squash_tag = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (d2_count !== 2'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", d2_count); end
        n_cmp++; if (d2_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", d2_out_valid); end
        n_cmp++; if (d2_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", d2_in_ready); end
        n_cmp++; if (d2_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %0b want 1", d2_empty); end
        n_cmp++; if (d2_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %0b want 0", d2_full); end
        n_cmp++; if (d2_squashed !== 16'd0) begin n_err++; $display("FAIL reset_squashed: got %0d want 0", d2_squashed); end
        n_cmp++; if (d2_out_data !== 16'd0) begin n_err++; $display("FAIL reset_out_data: got %0h want 0", d2_out_data); end
        n_cmp++; if (d2_out_tag !== 4'd0) begin n_err++; $display("FAIL reset_out_tag: got %0h want 0", d2_out_tag); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        in_valid = 1'b1; in_data = 16'hAAAA; in_tag = 4'd1;
        #1;
        n_cmp++; if (d2_out_valid !== 1'b0) begin n_err++; $display("FAIL fill_latency0: got %0b want 0", d2_out_valid); end
        tick();
        in_data = 16'hBBBB;
        #1;
        n_cmp++; if (d2_out_valid !== 1'b1) begin n_err++; $display("FAIL fill_latency1: got %0b want 1", d2_out_valid); end
        n_cmp++; if (d2_count !== 2'd1) begin n_err++; $display("FAIL fill_count1: got %0d want 1", d2_count); end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (d2_full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %0b want 1", d2_full); end
        n_cmp++; if (d2_in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready: got %0b want 0", d2_in_ready); end
        n_cmp++; if (d2_out_data !== 16'hAAAA) begin n_err++; $display("FAIL fill_head: got %0h want aaaa", d2_out_data); end
        tick();
        n_cmp++; if (d2_out_data !== 16'hAAAA) begin n_err++; $display("FAIL fill_hold: got %0h want aaaa", d2_out_data); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (d2_out_valid !== 1'b1) begin n_err++; $display("FAIL drain_a_valid: got %0b want 1", d2_out_valid); end
        tick();
        n_cmp++; if (d2_out_data !== 16'hBBBB) begin n_err++; $display("FAIL drain_b: got %0h want bbbb", d2_out_data); end
        n_cmp++; if (d2_count !== 2'd1) begin n_err++; $display("FAIL drain_count: got %0d want 1", d2_count); end
        tick();
        n_cmp++; if (d2_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %0b want 1", d2_empty); end
        n_cmp++; if (d2_out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %0b want 0", d2_out_valid); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        logic [15:0] exp_data;
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_tag = 4'd1; in_data = 16'h0100;
        #1;
        n_cmp++; if (d3_out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_start_valid: got %0b want 0", d3_out_valid); end
        for (int k = 1; k < 10; k++) begin
            tick();
            in_data = 16'h0100 + 16'(k);
            exp_data = 16'h0100 + 16'(k - 1);
            #1;
            n_cmp++; if (d3_out_valid !== 1'b1 || d3_out_data !== exp_data) begin
                n_err++; $display("FAIL wrap_order[%0d]: got %0b/%0h want 1/%0h", k, d3_out_valid, d3_out_data, exp_data);
            end
            n_cmp++; if (d3_count !== 2'd1) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want 1", k, d3_count); end
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (d3_out_data !== 16'h0109) begin n_err++; $display("FAIL wrap_last: got %0h want 109", d3_out_data); end
        tick();
        n_cmp++; if (d3_empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %0b want 1", d3_empty); end
        idle_inputs();
    endtask

    task automatic test_squash();
        do_reset();
        in_valid = 1'b1; in_tag = 4'd2; in_data = 16'h0C01;
        tick();
        in_data = 16'h0C02;
        tick();
        in_data = 16'h0C03; in_tag = 4'd3; squash = 1'b1; squash_tag = 4'd3;
        #1;
        n_cmp++; if (d3_out_valid !== 1'b0) begin n_err++; $display("FAIL squash_head_hidden: got %0b want 0", d3_out_valid); end
        tick();
        in_valid = 1'b0; squash = 1'b0;
        #1;
        n_cmp++; if (d3_out_valid !== 1'b0) begin n_err++; $display("FAIL squash_skip1: got %0b want 0", d3_out_valid); end
        n_cmp++; if (d3_count !== 2'd3) begin n_err++; $display("FAIL squash_count3: got %0d want 3", d3_count); end
        n_cmp++; if (d3_squashed !== 16'd2) begin n_err++; $display("FAIL squash_stat: got %0d want 2", d3_squashed); end
        tick();
        n_cmp++; if (d3_out_valid !== 1'b0) begin n_err++; $display("FAIL squash_skip2: got %0b want 0", d3_out_valid); end
        n_cmp++; if (d3_count !== 2'd2) begin n_err++; $display("FAIL squash_count2: got %0d want 2", d3_count); end
        tick();
        n_cmp++; if (d3_out_valid !== 1'b1 || d3_out_data !== 16'h0C03 || d3_out_tag !== 4'd3) begin
            n_err++; $display("FAIL squash_z: got %0b/%0h/%0h want 1/c03/3", d3_out_valid, d3_out_data, d3_out_tag);
        end
        n_cmp++; if (d3_count !== 2'd1) begin n_err++; $display("FAIL squash_count1: got %0d want 1", d3_count); end
        idle_inputs();
    endtask

    task automatic test_fallthrough();
        do_reset();
        in_valid = 1'b1; in_data = 16'h5EED; in_tag = 4'd4; out_ready = 1'b1;
        #1;
        n_cmp++; if (ft_out_valid !== 1'b1 || ft_out_data !== 16'h5EED || ft_out_tag !== 4'd4) begin
            n_err++; $display("FAIL ft_pass: got %0b/%0h/%0h want 1/5eed/4", ft_out_valid, ft_out_data, ft_out_tag);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (ft_count !== 2'd0) begin n_err++; $display("FAIL ft_count: got %0d want 0", ft_count); end
        n_cmp++; if (ft_out_valid !== 1'b0) begin n_err++; $display("FAIL ft_after: got %0b want 0", ft_out_valid); end
        idle_inputs();
    endtask

    task automatic test_same_cycle_kill();
        do_reset();
        in_valid = 1'b1; in_data = 16'h00DD; in_tag = 4'd5; out_ready = 1'b1;
        squash = 1'b1; squash_tag = 4'd6;
        #1;
        n_cmp++; if (ft_out_valid !== 1'b0) begin n_err++; $display("FAIL kill_valid: got %0b want 0", ft_out_valid); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (ft_count !== 2'd0) begin n_err++; $display("FAIL kill_count: got %0d want 0", ft_count); end
        n_cmp++; if (ft_squashed !== 16'd1) begin n_err++; $display("FAIL kill_stat: got %0d want 1", ft_squashed); end
        n_cmp++; if (ft_out_valid !== 1'b0) begin n_err++; $display("FAIL kill_after: got %0b want 0", ft_out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1; in_data = 16'h0011; in_tag = 4'd1;
        tick();
        in_data = 16'h0022; in_tag = 4'd2; squash = 1'b1; squash_tag = 4'd2;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (d2_count !== 2'd2) begin n_err++; $display("FAIL mid_pre_count: got %0d want 2", d2_count); end
        n_cmp++; if (d2_squashed !== 16'd1) begin n_err++; $display("FAIL mid_pre_stat: got %0d want 1", d2_squashed); end
        reset = 1'b0;
        #1;
        n_cmp++; if (d2_count !== 2'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", d2_count); end
        n_cmp++; if (d2_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %0b want 0", d2_out_valid); end
        n_cmp++; if (d2_squashed !== 16'd0) begin n_err++; $display("FAIL mid_stat: got %0d want 0", d2_squashed); end
        n_cmp++; if (d2_in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %0b want 1", d2_in_ready); end
        tick();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_squash();
        test_fallthrough();
        test_same_cycle_kill();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
